// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: in-order allocation and retirement of reg-write, store, branch and halt
// entries, out-of-order completion over CDB_PORTS writeback ports, and flush on a taken branch.
module rob_multiport #(
    parameter int DEPTH     = 8,
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int CDB_PORTS = 2,
    parameter int TAG_W     = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  logic [1:0]                     alloc_kind,
    input  logic [REG_INDEX-1:0]           alloc_rdest,
    input  logic [WORD_SIZE-1:0]           alloc_target,
    output logic [TAG_W-1:0]               alloc_tag,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]     cdb_tag,
    input  logic [CDB_PORTS*WORD_SIZE-1:0] cdb_data,
    input  logic [CDB_PORTS*WORD_SIZE-1:0] cdb_addr,
    input  logic [CDB_PORTS-1:0]           cdb_taken,
    input  logic [2*TAG_W-1:0]             rd_tag,
    output logic [1:0]                     rd_done,
    output logic [2*WORD_SIZE-1:0]         rd_data,
    output logic                           reg_we,
    output logic [REG_INDEX-1:0]           reg_ws,
    output logic [WORD_SIZE-1:0]           reg_wd,
    output logic                           mem_we,
    output logic [WORD_SIZE-1:0]           mem_ws,
    output logic [WORD_SIZE-1:0]           mem_wd,
    input  logic                           mem_ready,
    output logic                           redirect_valid,
    output logic [WORD_SIZE-1:0]           redirect_pc,
    output logic                           flush,
    output logic [TAG_W:0]                 count,
    output logic                           full,
    output logic                           empty,
    output logic                           halted
);

    typedef enum logic [1:0] {
        KIND_REG    = 2'b00,
        KIND_STORE  = 2'b01,
        KIND_BRANCH = 2'b10,
        KIND_HALT   = 2'b11
    } kind_e;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]     ent_valid;
    logic [DEPTH-1:0]     ent_done;
    kind_e                ent_kind   [DEPTH];
    logic [REG_INDEX-1:0] ent_rdest  [DEPTH];
    logic [WORD_SIZE-1:0] ent_target [DEPTH];
    logic [WORD_SIZE-1:0] ent_data   [DEPTH];
    logic [WORD_SIZE-1:0] ent_addr   [DEPTH];
    logic [DEPTH-1:0]     ent_taken;

    logic [TAG_W-1:0]     head;
    logic [TAG_W-1:0]     tail;
    logic [CDB_PORTS-1:0] cdb_win;
    logic                 head_ready;
    kind_e                head_kind;
    logic                 flush_pending;
    logic                 commit_fire;
    logic                 alloc_fire;

    // Everything the head drives is decoded from registered state, so a CDB write retires no
    // earlier than the following cycle.
    assign head_ready    = ent_valid[head] && ent_done[head];
    assign head_kind     = ent_kind[head];
    assign flush_pending = head_ready && (head_kind == KIND_BRANCH) && ent_taken[head];
    assign commit_fire   = head_ready && !flush_pending &&
                           ((head_kind != KIND_STORE) || mem_ready);

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign alloc_ready = !full && !halted && !flush_pending;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail;

    assign reg_we         = head_ready && (head_kind == KIND_REG);
    assign reg_ws         = ent_rdest[head];
    assign reg_wd         = ent_data[head];
    assign mem_we         = head_ready && (head_kind == KIND_STORE);
    assign mem_ws         = ent_addr[head];
    assign mem_wd         = ent_data[head];
    assign redirect_valid = flush_pending;
    assign redirect_pc    = ent_target[head];
    assign flush          = flush_pending;

    // A port wins only if its entry is live and not done, and no lower port names the same tag.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        cdb_win = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_win[p] = cdb_valid[p] && ent_valid[cdb_tag[p*TAG_W +: TAG_W]] &&
                         !ent_done[cdb_tag[p*TAG_W +: TAG_W]];
            for (int q = 0; q < p; q++) begin
                if (cdb_valid[q] && (cdb_tag[q*TAG_W +: TAG_W] == cdb_tag[p*TAG_W +: TAG_W]))
                    cdb_win[p] = 1'b0;
            end
        end
    end

    always_comb begin
        rd_done = '0;
        rd_data = '0;
        for (int k = 0; k < 2; k++) begin
            rd_done[k] = ent_valid[rd_tag[k*TAG_W +: TAG_W]] && ent_done[rd_tag[k*TAG_W +: TAG_W]];
            rd_data[k*WORD_SIZE +: WORD_SIZE] = ent_data[rd_tag[k*TAG_W +: TAG_W]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            halted    <= 1'b0;
        end else if (flush_pending) begin
            // Taken branch at head: squash everything younger; same-cycle CDB writes are dropped.
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= tail;
            count     <= '0;
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_win[p])
                    ent_done[cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
            end
            if (commit_fire) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
                head            <= head + TAG_W'(1);
                if (head_kind == KIND_HALT)
                    halted <= 1'b1;
            end
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + TAG_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; the valid/done bits alone decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_kind[tail]   <= kind_e'(alloc_kind);
            ent_rdest[tail]  <= alloc_rdest;
            ent_target[tail] <= alloc_target;
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_win[p]) begin
                ent_data[cdb_tag[p*TAG_W +: TAG_W]]  <= cdb_data[p*WORD_SIZE +: WORD_SIZE];
                ent_addr[cdb_tag[p*TAG_W +: TAG_W]]  <= cdb_addr[p*WORD_SIZE +: WORD_SIZE];
                ent_taken[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_taken[p];
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: a queue-based model of the ROB compared every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_rob_multiport;

    localparam int DEPTH = 8;
    localparam int WS    = 32;
    localparam int RI    = 5;
    localparam int CP    = 2;
    localparam int TW    = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic [1:0]        alloc_kind = '0;
    logic [RI-1:0]     alloc_rdest = '0;
    logic [WS-1:0]     alloc_target = '0;
    logic [TW-1:0]     alloc_tag;
    logic [CP-1:0]     cdb_valid = '0;
    logic [CP*TW-1:0]  cdb_tag = '0;
    logic [CP*WS-1:0]  cdb_data = '0;
    logic [CP*WS-1:0]  cdb_addr = '0;
    logic [CP-1:0]     cdb_taken = '0;
    logic [2*TW-1:0]   rd_tag = '0;
    logic [1:0]        rd_done;
    logic [2*WS-1:0]   rd_data;
    logic              reg_we;
    logic [RI-1:0]     reg_ws;
    logic [WS-1:0]     reg_wd;
    logic              mem_we;
    logic [WS-1:0]     mem_ws;
    logic [WS-1:0]     mem_wd;
    logic              mem_ready = 1'b0;
    logic              redirect_valid;
    logic [WS-1:0]     redirect_pc;
    logic              flush;
    logic [TW:0]       count;
    logic              full;
    logic              empty;
    logic              halted;

    rob_multiport #(.DEPTH(DEPTH), .WORD_SIZE(WS), .REG_INDEX(RI), .CDB_PORTS(CP)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
        .alloc_rdest(alloc_rdest), .alloc_target(alloc_target), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_addr(cdb_addr),
        .cdb_taken(cdb_taken), .rd_tag(rd_tag), .rd_done(rd_done), .rd_data(rd_data),
        .reg_we(reg_we), .reg_ws(reg_ws), .reg_wd(reg_wd),
        .mem_we(mem_we), .mem_ws(mem_ws), .mem_wd(mem_wd), .mem_ready(mem_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .count(count), .full(full), .empty(empty), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: program-order list of in-flight instructions, oldest first.
    typedef struct {
        logic [TW-1:0] tag;
        logic [1:0]    kind;
        logic [RI-1:0] rdest;
        logic [WS-1:0] target;
        bit            done;
        logic [WS-1:0] data;
        logic [WS-1:0] addr;
        bit            taken;
    } ent_t;

    ent_t mq[$];
    int   m_tail = 0;
    bit   m_halted = 1'b0;

    function automatic bit m_flush();
        return mq.size() > 0 && mq[0].done && mq[0].kind == 2'b10 && mq[0].taken;
    endfunction

    function automatic bit m_ready();
        return mq.size() < DEPTH && !m_halted && !m_flush();
    endfunction

    always @(posedge clk or negedge reset) begin : model
        if (!reset) begin
            mq.delete();
            m_tail   = 0;
            m_halted = 1'b0;
        end else begin
            bit   acc;
            bit   do_commit;
            bit   do_flush;
            ent_t e;
            acc       = alloc_valid && m_ready();
            do_flush  = m_flush();
            do_commit = !do_flush && mq.size() > 0 && mq[0].done &&
                        (mq[0].kind != 2'b01 || mem_ready);
            if (do_flush) begin
                mq.delete();
            end else begin
                for (int p = 0; p < CP; p++) begin
                    if (cdb_valid[p]) begin
                        foreach (mq[i]) begin
                            if (mq[i].tag == cdb_tag[p*TW +: TW] && !mq[i].done) begin
                                e       = mq[i];
                                e.done  = 1'b1;
                                e.data  = cdb_data[p*WS +: WS];
                                e.addr  = cdb_addr[p*WS +: WS];
                                e.taken = cdb_taken[p];
                                mq[i]   = e;
                            end
                        end
                    end
                end
                if (do_commit) begin
                    if (mq[0].kind == 2'b11) m_halted = 1'b1;
                    void'(mq.pop_front());
                end
                if (acc) begin
                    e.tag    = TW'(m_tail);
                    e.kind   = alloc_kind;
                    e.rdest  = alloc_rdest;
                    e.target = alloc_target;
                    e.done   = 1'b0;
                    e.data   = '0;
                    e.addr   = '0;
                    e.taken  = 1'b0;
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit hv;
        hv = mq.size() > 0 && mq[0].done;
        check("count", count, mq.size());
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, mq.size() == 0);
        check("halted", halted, m_halted);
        check("alloc_ready", alloc_ready, m_ready());
        check("alloc_tag", alloc_tag, m_tail);
        check("reg_we", reg_we, hv && mq[0].kind == 2'b00);
        if (hv && mq[0].kind == 2'b00) begin
            check("reg_ws", reg_ws, mq[0].rdest);
            check("reg_wd", reg_wd, mq[0].data);
        end
        check("mem_we", mem_we, hv && mq[0].kind == 2'b01);
        if (hv && mq[0].kind == 2'b01) begin
            check("mem_ws", mem_ws, mq[0].addr);
            check("mem_wd", mem_wd, mq[0].data);
        end
        check("redirect_valid", redirect_valid, m_flush());
        check("flush", flush, m_flush());
        if (m_flush()) check("redirect_pc", redirect_pc, mq[0].target);
        for (int k = 0; k < 2; k++) begin
            bit            fd;
            logic [WS-1:0] fdat;
            fd   = 1'b0;
            fdat = '0;
            foreach (mq[i]) begin
                if (mq[i].tag == rd_tag[k*TW +: TW] && mq[i].done) begin
                    fd   = 1'b1;
                    fdat = mq[i].data;
                end
            end
            check("rd_done", rd_done[k], fd);
            if (fd) check("rd_data", rd_data[k*WS +: WS], fdat);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid   = '0;
        cdb_taken   = '0;
    endtask

    task automatic set_alloc(input logic [1:0] k, input logic [RI-1:0] rd, input logic [WS-1:0] tgt);
        alloc_valid  = 1'b1;
        alloc_kind   = k;
        alloc_rdest  = rd;
        alloc_target = tgt;
    endtask

    task automatic set_cdb(input int p, input logic [TW-1:0] t, input logic [WS-1:0] d,
                           input logic [WS-1:0] a, input bit tk);
        cdb_valid[p]         = 1'b1;
        cdb_tag[p*TW +: TW]  = t;
        cdb_data[p*WS +: WS] = d;
        cdb_addr[p*WS +: WS] = a;
        cdb_taken[p]         = tk;
    endtask

    task automatic wait_empty(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (empty) break;
            step();
        end
        check(name, empty, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int highs;
        idle();
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", alloc_ready, 1);
        check("rst_count", count, 0);

        // Fill all eight entries, then hold a ninth request against a full buffer.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_tag", alloc_tag, i);
            set_alloc(2'b00, RI'(i + 1), '0);
            step();
        end
        check("full_flag", full, 1);
        check("full_ready", alloc_ready, 0);
        check("full_count", count, 8);
        step();
        check("stall_count", count, 8);
        set_cdb(0, 3'd0, 32'h100, '0, 1'b0);
        step();
        cdb_valid = '0;
        check("full_commit_we", reg_we, 1);
        check("full_commit_ready", alloc_ready, 0);
        step();
        idle();
        check("full_commit_count", count, 7);
        for (int t = 1; t < DEPTH; t += 2) begin
            set_cdb(0, TW'(t), 32'h100 + t, '0, 1'b0);
            if (t + 1 < DEPTH) set_cdb(1, TW'(t + 1), 32'h101 + t, '0, 1'b0);
            step();
            idle();
        end
        wait_empty(20, "full_drain");

        // Out-of-order completion, in-order commit.
        set_alloc(2'b00, 5'd10, '0);
        step();
        set_alloc(2'b00, 5'd11, '0);
        step();
        idle();
        check("ooo_tail", alloc_tag, 2);
        rd_tag = {3'd1, 3'd0};
        set_cdb(1, 3'd1, 32'h22, '0, 1'b0);
        step();
        idle();
        check("ooo_rd_done", rd_done, 2'b10);
        check("ooo_rd_data", rd_data[63:32], 32'h22);
        check("ooo_no_commit", reg_we, 0);
        set_cdb(0, 3'd0, 32'h11, '0, 1'b0);
        step();
        idle();
        check("ooo_we0", reg_we, 1);
        check("ooo_wd0", reg_wd, 32'h11);
        step();
        check("ooo_we1", reg_we, 1);
        check("ooo_wd1", reg_wd, 32'h22);
        step();
        check("ooo_empty", empty, 1);

        // Both ports complete tag 3 in one cycle: port 0 wins.
        set_alloc(2'b00, 5'd12, '0);
        step();
        set_alloc(2'b00, 5'd13, '0);
        step();
        idle();
        set_cdb(0, 3'd2, 32'h5, '0, 1'b0);
        step();
        idle();
        set_cdb(0, 3'd3, 32'hA, '0, 1'b0);
        set_cdb(1, 3'd3, 32'hB, '0, 1'b0);
        step();
        idle();
        check("prio_we", reg_we, 1);
        check("prio_ws", reg_ws, 13);
        check("prio_wd", reg_wd, 32'hA);
        step();
        check("prio_empty", empty, 1);

        // Store held by mem_ready low for three cycles.
        set_alloc(2'b01, '0, '0);
        step();
        idle();
        set_cdb(0, 3'd4, 32'hDEADBEEF, 32'h100, 1'b0);
        step();
        idle();
        highs = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            check("store_mem_we", mem_we, 1);
            check("store_mem_ws", mem_ws, 32'h100);
            check("store_count", count, 1);
            if (mem_we) highs++;
            step();
        end
        mem_ready = 1'b0;
        check("store_released", mem_we, 0);
        check("store_empty", empty, 1);
        check("store_high_cycles", highs, 4);

        // Move head to tag 2 across the wrap point.
        for (int i = 0; i < 5; i++) begin
            set_alloc(2'b00, RI'(20 + i), '0);
            step();
        end
        idle();
        set_cdb(0, 3'd5, 32'h50, '0, 1'b0);
        set_cdb(1, 3'd6, 32'h60, '0, 1'b0);
        step();
        idle();
        set_cdb(0, 3'd7, 32'h70, '0, 1'b0);
        set_cdb(1, 3'd0, 32'h80, '0, 1'b0);
        step();
        idle();
        set_cdb(0, 3'd1, 32'h90, '0, 1'b0);
        step();
        idle();
        wait_empty(20, "filler_drain");
        check("branch_head_tag", alloc_tag, 2);

        // Taken branch at tag 2 with tags 3..5 behind it.
        set_alloc(2'b10, '0, 32'h40);
        step();
        for (int i = 0; i < 3; i++) begin
            set_alloc(2'b00, RI'(1 + i), '0);
            step();
        end
        idle();
        set_cdb(0, 3'd2, '0, '0, 1'b1);
        set_cdb(1, 3'd3, 32'h33, '0, 1'b0);
        step();
        idle();
        check("br_redirect", redirect_valid, 1);
        check("br_flush", flush, 1);
        check("br_pc", redirect_pc, 32'h40);
        check("br_ready", alloc_ready, 0);
        check("br_count", count, 4);
        set_alloc(2'b00, 5'd1, '0);
        set_cdb(0, 3'd4, 32'h44, '0, 1'b0);
        rd_tag = {3'd3, 3'd4};
        step();
        idle();
        check("br_flush_done", flush, 0);
        check("br_count_after", count, 0);
        check("br_empty_after", empty, 1);
        check("br_tail_kept", alloc_tag, 6);
        check("br_rd_cleared", rd_done, 2'b00);

        // Twenty alloc/commit pairs crossing the 7->0 wrap with occupancy held at 2.
        for (int i = 0; i < 20; i++) begin
            check("wrap_tag", alloc_tag, (6 + i) % DEPTH);
            if (i >= 2) begin
                check("wrap_count", count, 2);
                check("wrap_we", reg_we, 1);
                check("wrap_wd", reg_wd, 32'h1000 + i - 2);
            end
            set_alloc(2'b00, RI'(i), '0);
            cdb_valid = '0;
            if (i > 0) set_cdb(0, TW'((6 + i - 1) % DEPTH), 32'h1000 + i - 1, '0, 1'b0);
            step();
        end
        idle();
        set_cdb(0, 3'd1, 32'h1000 + 19, '0, 1'b0);
        step();
        idle();
        wait_empty(10, "wrap_drain");

        // Halt: sticky, blocks allocation, younger entries still drain.
        set_alloc(2'b00, 5'd7, '0);
        step();
        set_alloc(2'b11, '0, '0);
        step();
        set_alloc(2'b00, 5'd8, '0);
        step();
        idle();
        set_cdb(0, 3'd2, 32'h77, '0, 1'b0);
        set_cdb(1, 3'd3, '0, '0, 1'b0);
        step();
        idle();
        set_cdb(0, 3'd4, 32'h88, '0, 1'b0);
        step();
        idle();
        wait_empty(10, "halt_drain");
        check("halt_sticky", halted, 1);
        check("halt_blocks", alloc_ready, 0);
        set_alloc(2'b00, 5'd9, '0);
        step();
        idle();
        check("halt_no_alloc", count, 0);

        // Reset clears halt; reset in the middle of a store drops mem_we at once.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("rst2_halted", halted, 0);
        check("rst2_ready", alloc_ready, 1);
        set_alloc(2'b01, '0, '0);
        step();
        idle();
        set_cdb(0, 3'd0, 32'h55, 32'h200, 1'b0);
        step();
        idle();
        check("rst_store_we", mem_we, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_mem_we", mem_we, 0);
        check("rst_mid_empty", empty, 1);
        step();
        reset = 1'b1;
        step();
        check("post_rst_ready", alloc_ready, 1);
        check("post_rst_mem_we", mem_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
